// File: rtl/s_mem_resp.sv
// S-box memory responder: self-fills to the identity permutation, then serves 1-cycle-latency reads/writes.
// Optional accepted-write counter enabled by defining SMEM_WR_COUNT_EN.
module s_mem_resp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  output logic              rdy,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              wren,
  output logic [DATA_W-1:0] rddata
`ifdef SMEM_WR_COUNT_EN
  ,
  output logic [15:0]       wr_count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   fill_idx_reg, fill_idx_next;
  logic [DATA_W-1:0]   rddata_reg;
  logic [DATA_W-1:0]   fill_data;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                rd_en;
  logic                rd_clear;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Identity fill value: fill index zero-extended to the entry width.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_fill
      if (gi < ADDR_W) begin : g_idx
        assign fill_data[gi] = fill_idx_reg[gi];
      end else begin : g_zero
        assign fill_data[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FILL;
      fill_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_idx_reg <= fill_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_idx_next = fill_idx_reg;
    mem_we        = 1'b0;
    mem_waddr     = addr;
    mem_wdata     = wrdata;
    rd_en         = 1'b0;
    rd_clear      = 1'b0;
    case (state_reg)
      FILL: begin
        mem_we        = 1'b1;
        mem_waddr     = fill_idx_reg;
        mem_wdata     = fill_data;
        fill_idx_next = fill_idx_reg + 1'b1;
        rd_clear      = 1'b1;
        if (fill_idx_reg == {ADDR_W{1'b1}}) begin
          state_next = READY;
        end
      end
      READY: begin
        // init wins over a concurrent write, which is dropped.
        if (init) begin
          state_next    = FILL;
          fill_idx_next = '0;
          rd_clear      = 1'b1;
        end else begin
          rd_en  = 1'b1;
          mem_we = wren;
        end
      end
      default: begin
        state_next    = FILL;
        fill_idx_next = '0;
      end
    endcase
  end

  // Array kept free of reset so it maps onto block RAM; read-first ordering.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rd_clear) begin
      rddata_reg <= '0;
    end else if (rd_en) begin
      rddata_reg <= mem[addr];
    end
  end

  assign rddata = rddata_reg;
  assign rdy    = (state_reg == READY);

`ifdef SMEM_WR_COUNT_EN
  logic [15:0] wr_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_reg <= '0;
    end else if (state_reg == READY) begin
      if (init) begin
        wr_count_reg <= '0;
      end else if (wren && (wr_count_reg != 16'hFFFF)) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
    end
  end

  assign wr_count = wr_count_reg;
`endif

endmodule

// File: doc/s_mem_resp.md
Name: s_mem_resp

Overview:
- Responder end of the S-box memory interface (addr/rddata/wrdata/wren) driven by the key-scheduling and keystream engines of the ARC4 cracker.
- Holds the 2^ADDR_W-entry S array.
- Self-initialises to the identity permutation (S[i]=i) after reset or on request, then serves single-port reads and writes with fixed one-cycle read latency.
- Raises rdy once initialisation completes, so an initiator may start scheduling.

Parameters:
- ADDR_W, 8, address width; depth = 2^ADDR_W entries.
- DATA_W, 8, entry width; must be >= ADDR_W (identity fill value is zero-extended index).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- init  input  1  request re-fill to identity; honoured only while rdy=1.
- rdy  output  1  1 = array initialised and port accepting accesses.
- addr  input  ADDR_W  access address.
- wrdata  input  DATA_W  write data.
- wren  input  1  write strobe, sampled on rising edge.
- rddata  output  DATA_W  registered read data.
- wr_count  output  16  accepted-write counter; present only with SMEM_WR_COUNT_EN.

Behaviour:
- Reset: clk rising edge with rst=1 gives state FILL, fill_idx=0, rdy=0, rddata=0, wr_count=0. Array contents undefined until refilled.
- States: FILL, READY.
- FILL, each edge with rst=0:
  - mem[fill_idx] <= fill_idx (zero-extended); fill_idx++; rddata <= 0; wren/addr ignored.
- FILL exit: the edge that writes index 2^ADDR_W-1 moves to READY and sets rdy=1.
  - With ADDR_W=8, rdy is first high after the 256th edge following rst deassertion.
- READY, each edge:
  - rddata <= mem[addr] (read-first): read data for the address presented at edge N is valid after edge N, usable before edge N+1.
  - If wren=1: mem[addr] <= wrdata on the same edge.
  - Simultaneous read and write to the same address returns the OLD value; the new value is visible on the next read.
  - Back-to-back accesses allowed every cycle; no stall, no back-pressure.
- READY with init=1: next edge enters FILL, fill_idx=0, rdy=0, rddata <= 0.
  - Any wren in that same cycle is dropped (init has priority).
  - Fill takes 2^ADDR_W edges, as after reset.
- init while rdy=0: ignored; the fill in progress continues and does not restart.
- rst during FILL or READY: immediate restart of FILL from index 0 at that edge; rst dominates init and wren.
- fill_idx wraps naturally at 2^ADDR_W; the terminal index is detected explicitly. No out-of-range address is possible.
- Initiator protocol:
  - Must not issue accesses while rdy=0; such accesses have no effect and are not errors.
  - rdy stays high until init or rst.

Optional Feature:
- Macro SMEM_WR_COUNT_EN.
- Defined:
  - Port wr_count[15:0] exists.
  - Increments by 1 on each edge in READY where wren=1, init=0, rst=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst and on the init-accept edge.
  - Not incremented during FILL.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset fill: rst=1 for 2 edges, then 0 → rdy=0 for 255 edges, rdy=1 after edge 256. Reading addr 0, 0x37, 0xFF returns 0x00, 0x37, 0xFF one cycle later.
- Write/read: wren=1, addr=0x10, wrdata=0xA5, then read 0x10 → rddata=0xA5 after the read edge; addr 0x11 still 0x11.
- Read-during-write same address: with mem[0x20]=0x20, present addr=0x20, wren=1, wrdata=0x5A → rddata=0x20 after that edge. Next cycle read of 0x20 → 0x5A.
- Swap sequence as the key scheduler issues it:
  - Initial state: S[3]=3, S[200]=200.
  - Sequence: read 3, read 200, write 3←200, write 200←3.
  - Expected: reads return 3 and 200; subsequent reads return 200 and 3.
- init and mid-operation reset:
  - After modifying 0x10, pulse init with wren=1 to 0x40/0xEE → write dropped, rdy=0 for 256 edges, then S[0x10]=0x10 and S[0x40]=0x40.
  - Assert rst at fill index 100 → fill restarts; rdy rises 256 edges after rst release.
- SMEM_WR_COUNT_EN: 5 writes in READY give wr_count=5. A write during FILL leaves it unchanged. An init accept clears it to 0. Forcing 65536 writes gives wr_count=16'hFFFF (saturated).
